// File: rtl/hazard_controller_pkg.sv
// Shared core package for the hazard controller.
// Holds the FSM state encoding and the register-index width.
package hazard_controller_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the core pipeline and the hazard controller.
// master = core side, slave = hazard controller.
interface hazard_controller_if #(
    parameter int CNT_W = 32
) ();
    import hazard_controller_pkg::*;

    logic [REG_W-1:0] i_rs1_d;
    logic [REG_W-1:0] i_rs2_d;
    logic             i_use_rs1_d;
    logic             i_use_rs2_d;
    logic [REG_W-1:0] i_rd_e;
    logic             i_mem_read_e;
    logic             i_branch_e;
    logic             i_mc_start_e;
    logic             i_mc_done;
    logic             i_dmem_wait;

    logic             o_stall_f;
    logic             o_stall_d;
    logic             o_stall_e;
    logic             o_stall_m;
    logic             o_flush_d;
    logic             o_flush_e;
    logic             o_flush_m;
    logic             o_flush_w;
    logic             o_mc_go;
    logic             o_mc_timeout;
    logic             o_busy;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_rs1_d, i_rs2_d, i_use_rs1_d, i_use_rs2_d,
        output i_rd_e, i_mem_read_e, i_branch_e,
        output i_mc_start_e, i_mc_done, i_dmem_wait,
        input  o_stall_f, o_stall_d, o_stall_e, o_stall_m,
        input  o_flush_d, o_flush_e, o_flush_m, o_flush_w,
        input  o_mc_go, o_mc_timeout, o_busy, o_stall_cnt
    );

    modport slave (
        input  i_rs1_d, i_rs2_d, i_use_rs1_d, i_use_rs2_d,
        input  i_rd_e, i_mem_read_e, i_branch_e,
        input  i_mc_start_e, i_mc_done, i_dmem_wait,
        output o_stall_f, o_stall_d, o_stall_e, o_stall_m,
        output o_flush_d, o_flush_e, o_flush_m, o_flush_w,
        output o_mc_go, o_mc_timeout, o_busy, o_stall_cnt
    );

endinterface

// File: rtl/hazard_controller_load_use.sv
// Load-use comparator: a load in E writing a register that decode reads.
// x0 is never a real dependency.
module load_use_detect
    import hazard_controller_pkg::*;
(
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             mem_read_e,
    output logic             hit
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = use_rs1_d && (rd_e == rs1_d);
    assign rs2_hit = use_rs2_d && (rd_e == rs2_d);
    assign hit     = mem_read_e && (rd_e != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: per-stage stall/flush, coprocessor handshake
// with timeout, and a stall-cycle performance counter.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MC_TIMEOUT = 255,
    parameter int TO_W       = 8,
    parameter int CNT_W      = 32
) (
    input logic          i_clk,
    input logic          i_rst_n,
    hazard_controller_if.slave hz
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MC_TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_nxt;
    logic             to_flag;
    logic             to_set;
    logic [CNT_W-1:0] stall_cnt;

    logic lu_hit;
    logic sf, sd, se, sm;
    logic fd, fe, fm, fw;
    logic go;

    load_use_detect u_lu (
        .rs1_d      (hz.i_rs1_d),
        .rs2_d      (hz.i_rs2_d),
        .use_rs1_d  (hz.i_use_rs1_d),
        .use_rs2_d  (hz.i_use_rs2_d),
        .rd_e       (hz.i_rd_e),
        .mem_read_e (hz.i_mem_read_e),
        .hit        (lu_hit)
    );

    // Priority: dmem_wait > MC_BUSY > branch > mc_start > load-use.
    always_comb begin
        sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
        fd = 1'b0; fe = 1'b0; fm = 1'b0; fw = 1'b0;
        go         = 1'b0;
        to_set     = 1'b0;
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        if (!i_rst_n) begin
            state_nxt = ST_RUN;
        end else if (hz.i_dmem_wait) begin
            sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
            fw = 1'b1;
        end else if (state == ST_MC_BUSY) begin
            if (hz.i_mc_done) begin
                state_nxt = ST_RUN;
            end else if (to_cnt == TO_LIM) begin
                to_set    = 1'b1;
                state_nxt = ST_RUN;
            end else begin
                sf = 1'b1; sd = 1'b1; se = 1'b1;
                fm = 1'b1;
                to_cnt_nxt = to_cnt + 1'b1;
            end
        end else if (hz.i_branch_e) begin
            fd = 1'b1; fe = 1'b1;
        end else if (hz.i_mc_start_e) begin
            go = 1'b1;
            sf = 1'b1; sd = 1'b1; se = 1'b1;
            fm = 1'b1;
            state_nxt  = ST_MC_BUSY;
            to_cnt_nxt = '0;
        end else if (lu_hit) begin
            sf = 1'b1; sd = 1'b1;
            fe = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_RUN;
            to_cnt    <= '0;
            to_flag   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            to_cnt    <= to_cnt_nxt;
            to_flag   <= to_flag | to_set;
            stall_cnt <= stall_cnt + CNT_W'(sf);
        end
    end

    assign hz.o_stall_f    = sf;
    assign hz.o_stall_d    = sd;
    assign hz.o_stall_e    = se;
    assign hz.o_stall_m    = sm;
    assign hz.o_flush_d    = fd;
    assign hz.o_flush_e    = fe;
    assign hz.o_flush_m    = fm;
    assign hz.o_flush_w    = fw;
    assign hz.o_mc_go      = go;
    assign hz.o_mc_timeout = to_flag;
    assign hz.o_busy       = (state == ST_MC_BUSY);
    assign hz.o_stall_cnt  = stall_cnt;

endmodule
